cnu_minsum: RTL and testbench

Offset min-sum check node unit for the layered QC-LDPC decoder. It sits directly downstream of the variable node adder-pair stage. For one parity-check row per pass, it collects the row's VN-to-CN messages (alpha), then emits one CN-to-VN message (beta_new) per edge in the same order. Those beta values go back to the variable node stage to form gamma_new.

---
 rtl/cnu_minsum.sv | 143 ++++++++++++++
 tb/tb_cnu_minsum.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cnu_minsum.sv
// Offset min-sum check node: collects one row of alpha messages, then streams
// the matching beta messages in edge order with no bubbles.
module cnu_minsum #(
    parameter int unsigned BITS    = 8,
    parameter int unsigned DEG_MAX = 16,
    parameter int unsigned IDXW    = $clog2(DEG_MAX),
    parameter int unsigned DEGW    = $clog2(DEG_MAX + 1),
    parameter int unsigned OFFSET  = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [DEGW-1:0]        i_deg,
    input  logic                   i_alpha_valid,
    input  logic signed [BITS-1:0] i_alpha,
    output logic                   o_beta_valid,
    output logic signed [BITS-1:0] o_beta,
    output logic                   o_done,
    output logic                   o_busy,
    output logic                   o_err
);

    typedef enum logic [1:0] {StIdle, StCollect, StEmit} state_e;

    localparam logic [BITS-2:0] MAG_MAX  = '1;
    localparam logic [BITS-2:0] OFF      = (BITS-1)'(OFFSET);
    localparam logic [BITS-1:0] MOST_NEG = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [DEGW-1:0] DEG_LO   = DEGW'(2);
    localparam logic [DEGW-1:0] DEG_HI   = DEGW'(DEG_MAX);
    localparam logic [DEGW-1:0] ONE      = DEGW'(1);

    state_e               r_state, w_state_next;
    logic [DEGW-1:0]      r_deg, r_cnt;
    logic [BITS-2:0]      r_min1, r_min2;
    logic [IDXW-1:0]      r_idx1;
    logic                 r_parity;
    logic [DEG_MAX-1:0]   r_signs;
    logic                 r_err;

    logic [IDXW-1:0]      w_k;
    logic                 w_legal, w_accept, w_coll_last, w_emit_last;
    logic [BITS-1:0]      w_alpha_neg;
    logic [BITS-2:0]      w_mag, w_m, w_mag_out;
    logic [BITS-1:0]      w_beta_mag;
    logic                 w_neg;

    assign w_k         = r_cnt[IDXW-1:0];
    assign w_legal     = (i_deg >= DEG_LO) && (i_deg <= DEG_HI);
    assign w_accept    = (r_state == StCollect) && i_alpha_valid;
    assign w_coll_last = w_accept && (r_cnt == r_deg - ONE);
    assign w_emit_last = (r_state == StEmit) && (r_cnt == r_deg - ONE);

    // |alpha| with the most negative code saturated to the largest magnitude
    assign w_alpha_neg = -i_alpha;
    assign w_mag = (i_alpha == MOST_NEG) ? MAG_MAX :
                   (i_alpha[BITS-1] ? w_alpha_neg[BITS-2:0] : i_alpha[BITS-2:0]);

    assign w_m        = (w_k == r_idx1) ? r_min2 : r_min1;
    assign w_mag_out  = (w_m > OFF) ? (w_m - OFF) : '0;
    assign w_neg      = r_parity ^ r_signs[w_k];
    assign w_beta_mag = {1'b0, w_mag_out};

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (i_start && w_legal) w_state_next = StCollect;
            StCollect: if (w_coll_last) w_state_next = StEmit;
            StEmit:    if (w_emit_last) w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_deg    <= '0;
            r_cnt    <= '0;
            r_min1   <= MAG_MAX;
            r_min2   <= MAG_MAX;
            r_idx1   <= '0;
            r_parity <= 1'b0;
            r_signs  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        if (w_legal) begin
                            r_deg    <= i_deg;
                            r_cnt    <= '0;
                            r_min1   <= MAG_MAX;
                            r_min2   <= MAG_MAX;
                            r_idx1   <= '0;
                            r_parity <= 1'b0;
                            r_signs  <= '0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                StCollect: begin
                    if (w_accept) begin
                        r_signs[w_k] <= i_alpha[BITS-1];
                        r_parity     <= r_parity ^ i_alpha[BITS-1];
                        // Ties with min1 fall through to min2 so idx1 keeps the first hit
                        if (w_mag < r_min1) begin
                            r_min2 <= r_min1;
                            r_min1 <= w_mag;
                            r_idx1 <= w_k;
                        end else if (w_mag < r_min2) begin
                            r_min2 <= w_mag;
                        end
                        r_cnt <= w_coll_last ? '0 : r_cnt + ONE;
                    end
                end
                StEmit: begin
                    r_cnt <= w_emit_last ? '0 : r_cnt + ONE;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    always_comb begin
        o_beta_valid = (r_state == StEmit);
        o_done       = w_emit_last;
        o_busy       = (r_state != StIdle);
        o_err        = r_err;
        o_beta       = '0;
        if (o_beta_valid) begin
            o_beta = w_neg ? -w_beta_mag : w_beta_mag;
        end
    end

endmodule

// File: tb/tb_cnu_minsum.sv
// Directed bench for cnu_minsum: hand-computed beta vectors, stalls, illegal
// degrees, mid-row reset and back-to-back rows.
module tb_cnu_minsum;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_start;
    logic [4:0]        i_deg;
    logic              i_alpha_valid;
    logic signed [7:0] i_alpha;
    logic              o_beta_valid;
    logic signed [7:0] o_beta;
    logic              o_done;
    logic              o_busy;
    logic              o_err;

    int n_checks = 0;
    int n_errors = 0;

    int q_a[$];
    int q_g[$];
    int q_e[$];

    cnu_minsum #(
        .BITS(8), .DEG_MAX(16), .OFFSET(1)
    ) u_dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_deg        (i_deg),
        .i_alpha_valid(i_alpha_valid),
        .i_alpha      (i_alpha),
        .o_beta_valid (o_beta_valid),
        .o_beta       (o_beta),
        .o_done       (o_done),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, int'(o_beta_valid), 0);
        check({tag, "_beta"},  int'(o_beta), 0);
        check({tag, "_done"},  int'(o_done), 0);
        check({tag, "_busy"},  int'(o_busy), 0);
    endtask

    // Starts a row in the current cycle; q_g holds idle cycles before each alpha.
    task automatic run_row(input string tag);
        int deg;
        deg = q_a.size();
        i_start = 1'b1;
        i_deg   = 5'(deg);
        tick();
        i_start = 1'b0;
        check({tag, "_busy_start"}, int'(o_busy), 1);
        for (int k = 0; k < deg; k++) begin
            for (int g = 0; g < q_g[k]; g++) begin
                i_alpha_valid = 1'b0;
                i_alpha       = 8'sd99;
                tick();
                check({tag, "_gap_valid"}, int'(o_beta_valid), 0);
            end
            i_alpha_valid = 1'b1;
            i_alpha       = 8'(q_a[k]);
            tick();
            if (k < deg - 1) check({tag, "_early_valid"}, int'(o_beta_valid), 0);
        end
        i_alpha_valid = 1'b0;
        i_alpha       = 8'sd0;
        for (int k = 0; k < deg; k++) begin
            check($sformatf("%s_valid%0d", tag, k), int'(o_beta_valid), 1);
            check($sformatf("%s_beta%0d", tag, k),  int'(o_beta), q_e[k]);
            check($sformatf("%s_done%0d", tag, k),  int'(o_done), (k == deg - 1) ? 1 : 0);
            tick();
        end
        check_idle_outputs({tag, "_end"});
    endtask

    initial begin
        i_rst_n       = 1'b0;
        i_start       = 1'b0;
        i_deg         = '0;
        i_alpha_valid = 1'b0;
        i_alpha       = '0;
        #12;
        check_idle_outputs("reset");
        check("reset_err", int'(o_err), 0);
        #2 i_rst_n = 1'b1;
        tick();

        // Basic, then tie and saturation rows started back-to-back at C+deg+1
        q_a = '{5, -3, 7, -2};   q_g = '{0, 0, 0, 0}; q_e = '{1, -1, 1, -2};
        run_row("basic");
        q_a = '{4, 4, -9};       q_g = '{0, 0, 0};    q_e = '{-3, -3, 3};
        run_row("tie");
        q_a = '{-128, 127};      q_g = '{0, 0};       q_e = '{126, -126};
        run_row("sat");
        q_a = '{0, 1, -5};       q_g = '{0, 0, 0};    q_e = '{0, 0, 0};
        run_row("zero");
        tick();

        q_a = '{5, -3, 7, -2};   q_g = '{0, 2, 1, 0}; q_e = '{1, -1, 1, -2};
        run_row("stall");

        // Illegal degrees; alpha_valid in IDLE must be ignored too
        i_alpha_valid = 1'b1;
        i_alpha       = -8'sd7;
        i_start = 1'b1; i_deg = 5'd1;
        tick();
        i_start = 1'b0;
        check("ill1_err", int'(o_err), 1);
        check("ill1_busy", int'(o_busy), 0);
        tick();
        check("ill1_err_clear", int'(o_err), 0);
        i_start = 1'b1; i_deg = 5'd17;
        tick();
        i_start = 1'b0;
        check("ill17_err", int'(o_err), 1);
        check("ill17_busy", int'(o_busy), 0);
        tick();
        check("ill17_err_clear", int'(o_err), 0);
        check_idle_outputs("ill17_idle");
        i_alpha_valid = 1'b0;

        // Reset after two of four alphas
        i_start = 1'b1; i_deg = 5'd4;
        tick();
        i_start = 1'b0;
        i_alpha_valid = 1'b1; i_alpha = 8'sd5;
        tick();
        i_alpha = -8'sd3;
        tick();
        i_alpha_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        #2 i_rst_n = 1'b1;
        tick();
        check_idle_outputs("midrst_after");

        q_a = '{-6, 2, 9, 3};    q_g = '{0, 0, 0, 0}; q_e = '{1, -2, -1, -1};
        run_row("fresh");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
